fixed_mul_pipe: RTL and testbench

Pipelined, parametrised signed fixed-point multiplier for the Julia iteration datapath (z² + c squaring and cross terms). It accepts a pair of Qm.FRAC operands per cycle under a valid/ready handshake and returns the rescaled product after a fixed latency. Rounding is selectable, and saturation with an overflow flag is optional. Full-throughput backpressure lets iteration engines stall it without losing in-flight products.

---
 rtl/fixed_pkg.sv | 28 ++
 rtl/fixed_round_sat.sv | 38 +++
 rtl/fixed_mul_pipe.sv | 106 ++++++++++
 tb/tb_fixed_mul_pipe.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_pkg.sv
// Shared fixed-point constants and helpers for the Julia datapath arithmetic blocks.
package fixed_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_FRAC  = 16;

  localparam int unsigned ROUND_TRUNC   = 0;
  localparam int unsigned ROUND_HALF_UP = 1;
  localparam int unsigned WRAP          = 0;
  localparam int unsigned SATURATE      = 1;

  localparam int unsigned MAX_WIDTH = 64;

  typedef logic [MAX_WIDTH-1:0] limit_t;

  // Largest (neg=0) or smallest (neg=1) width-bit signed value, sign-extended to MAX_WIDTH.
  function automatic limit_t sat_limit(input int unsigned width, input logic neg);
    limit_t ones;
    limit_t v;
    ones = '1;
    v    = ones << (width - 1);
    if (!neg) begin
      v = ~v;
    end
    return v;
  endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// Combinational rescale of a full-precision product: optional half-up rounding,
// arithmetic shift by FRAC, then clamp or wrap into WIDTH bits with an overflow flag.
module fixed_round_sat
  import fixed_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned FRAC  = DEF_FRAC,
  parameter int unsigned ROUND = ROUND_TRUNC,
  parameter int unsigned SAT   = SATURATE
) (
  input  logic [2*WIDTH-1:0] p,
  output logic [WIDTH-1:0]   result,
  output logic               overflow
);

  localparam int unsigned PW = 2*WIDTH + 1;
  localparam logic [PW-1:0] HALF = (ROUND == ROUND_HALF_UP) ? (PW'(1) << (FRAC - 1)) : '0;

  logic signed [PW-1:0] biased;
  logic signed [PW-1:0] shifted;
  logic [WIDTH+1:0]     upper;
  logic                 fit;

  always_comb begin
    // One extra bit keeps the rounding increment from wrapping the most positive product.
    biased   = $signed({p[2*WIDTH-1], p}) + $signed(HALF);
    shifted  = biased >>> FRAC;
    upper    = shifted[PW-1:WIDTH-1];
    fit      = (upper == '0) || (upper == '1);
    overflow = !fit;
    if (fit || (SAT == WRAP)) begin
      result = shifted[WIDTH-1:0];
    end else begin
      result = WIDTH'(sat_limit(WIDTH, shifted[PW-1]));
    end
  end

endmodule

// File: rtl/fixed_mul_pipe.sv
// Pipelined signed fixed-point multiplier with valid/ready flow control and a
// single global stall enable driven by output backpressure.
module fixed_mul_pipe
  import fixed_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned FRAC   = DEF_FRAC,
  parameter int unsigned STAGES = 3,
  parameter int unsigned ROUND  = ROUND_TRUNC,
  parameter int unsigned SAT    = SATURATE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int unsigned DLY = STAGES - 3;

  logic                 en;
  logic                 v1;
  logic                 v2;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic [2*WIDTH-1:0]   p_r;
  logic                 tail_v;
  logic [2*WIDTH-1:0]   tail_p;
  logic [WIDTH-1:0]     rs_result;
  logic                 rs_ovf;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      p_r <= '0;
    end else if (en) begin
      v1  <= in_valid;
      a_r <= a;
      b_r <= b;
      v2  <= v1;
      p_r <= $signed({{WIDTH{a_r[WIDTH-1]}}, a_r}) * $signed({{WIDTH{b_r[WIDTH-1]}}, b_r});
    end
  end

  if (DLY == 0) begin : g_nodly
    assign tail_v = v2;
    assign tail_p = p_r;
  end else begin : g_dly
    logic               dv [DLY];
    logic [2*WIDTH-1:0] dp [DLY];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < DLY; i++) begin
          dv[i] <= 1'b0;
          dp[i] <= '0;
        end
      end else if (en) begin
        dv[0] <= v2;
        dp[0] <= p_r;
        for (int unsigned i = 1; i < DLY; i++) begin
          dv[i] <= dv[i-1];
          dp[i] <= dp[i-1];
        end
      end
    end

    assign tail_v = dv[DLY-1];
    assign tail_p = dp[DLY-1];
  end

  fixed_round_sat #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .ROUND (ROUND),
    .SAT   (SAT)
  ) u_round_sat (
    .p        (tail_p),
    .result   (rs_result),
    .overflow (rs_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
    end else if (en) begin
      out_valid <= tail_v;
      result    <= rs_result;
      overflow  <= rs_ovf;
    end
  end

endmodule

// File: tb/tb_fixed_mul_pipe.sv
// Scoreboard bench: two multiplier configurations driven side by side, expected
// products computed with plain 64-bit arithmetic and checked by per-instance monitors.
module tb_fixed_mul_pipe;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int unsigned  cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst      = 1'b1;
  logic ordy     = 1'b1;
  logic stalling = 1'b0;
  logic use_tab  = 1'b0;
  logic chk_lat  = 1'b0;

  logic         iv [2];
  logic [W-1:0] av [2];
  logic [W-1:0] bv [2];
  int unsigned  idx [2];

  logic [W-1:0] pa [64];
  logic [W-1:0] pb [64];
  logic [W-1:0] tab_r [2][6];
  logic         tab_o [2][6];

  int unsigned cyc   = 0;
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference: exact integer product, optional +0.5 LSB, floor division by 2^16, range test.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input int unsigned rnd, input int unsigned sat);
    exp_t   r;
    longint sx, sy, p, s;
    logic [63:0] su;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = sx * sy;
    if (rnd != 0) p = p + 64'sd32768;
    s  = p >>> 16;
    su = s;
    r.cyc = 0;
    if (s >= -64'sd2147483648 && s <= 64'sd2147483647) begin
      r.res = su[31:0];
      r.ovf = 1'b0;
    end else begin
      r.ovf = 1'b1;
      if (sat != 0) r.res = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      else          r.res = su[31:0];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1, 2: v = $urandom_range(0, 32'h001F_FFFF) - 32'h0010_0000;
      default: begin
        case ($urandom_range(0, 3))
          0: v = 32'h8000_0000;
          1: v = 32'h7FFF_FFFF;
          2: v = 32'hFFFF_FFFF;
          default: v = 32'h0001_0000;
        endcase
      end
    endcase
    return v;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : ch
    localparam int unsigned ST   = (k == 0) ? 3 : 4;
    localparam int unsigned RND  = (k == 0) ? 0 : 1;
    localparam int unsigned SATP = (k == 0) ? 1 : 0;

    logic         ir, ov, ovf;
    logic [W-1:0] res;
    logic         acc = 1'b0;
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_res = '0;
    logic         prev_ovf = 1'b0;
    exp_t         q [$];
    exp_t         e;

    fixed_mul_pipe #(
      .WIDTH  (W),
      .FRAC   (16),
      .STAGES (ST),
      .ROUND  (RND),
      .SAT    (SATP)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[k]),
      .in_ready  (ir),
      .a         (av[k]),
      .b         (bv[k]),
      .out_valid (ov),
      .out_ready (ordy),
      .result    (res),
      .overflow  (ovf)
    );

    always @(negedge clk) begin
      acc = 1'b0;
      if (rst) begin
        q.delete();
        prev_hold = 1'b0;
      end else begin
        if (stalling && ov) begin
          chk($sformatf("in_ready_stall%0d", k), 64'(ir), 64'(0));
          if (prev_hold) begin
            chk($sformatf("hold_result%0d", k), 64'(res), 64'(prev_res));
            chk($sformatf("hold_ovf%0d", k), 64'(ovf), 64'(prev_ovf));
          end
        end
        prev_hold = stalling && ov;
        prev_res  = res;
        prev_ovf  = ovf;
        if (ov && ordy) begin
          if (q.size() == 0) begin
            chk($sformatf("unexpected_out%0d", k), 64'(ov), 64'(0));
          end else begin
            e = q.pop_front();
            chk($sformatf("result%0d", k), 64'(res), 64'(e.res));
            chk($sformatf("overflow%0d", k), 64'(ovf), 64'(e.ovf));
            if (chk_lat) chk($sformatf("latency%0d", k), 64'(cyc - e.cyc), 64'(ST));
          end
        end
        if (iv[k] && ir) begin
          acc = 1'b1;
          if (use_tab) begin
            e.res = tab_r[k][idx[k]];
            e.ovf = tab_o[k][idx[k]];
          end else begin
            e = model(av[k], bv[k], RND, SATP);
          end
          e.cyc = cyc;
          q.push_back(e);
        end
      end
    end
  end

  task automatic drain();
    for (int c = 0; c < 30; c++) begin
      if (ch[0].q.size() == 0 && ch[1].q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain0", 64'(ch[0].q.size()), 64'(0));
    chk("drain1", 64'(ch[1].q.size()), 64'(0));
  endtask

  task automatic run_phase(input int unsigned n, input int stall_at, input int stall_len,
                           input bit rnd_ready);
    idx[0] = 0;
    idx[1] = 0;
    for (int c = 0; c < 500; c++) begin
      if (idx[0] >= n && idx[1] >= n) break;
      for (int k = 0; k < 2; k++) begin
        iv[k] = (idx[k] < n);
        if (idx[k] < n) begin
          av[k] = pa[idx[k]];
          bv[k] = pb[idx[k]];
        end
      end
      if (rnd_ready) ordy = ($urandom_range(0, 3) != 0);
      else           ordy = !(c >= stall_at && c < stall_at + stall_len);
      stalling = !ordy;
      @(posedge clk); #1;
      if (ch[0].acc) idx[0]++;
      if (ch[1].acc) idx[1]++;
    end
    iv[0] = 1'b0;
    iv[1] = 1'b0;
    ordy = 1'b1;
    stalling = 1'b0;
    chk("accepted0", 64'(idx[0]), 64'(n));
    chk("accepted1", 64'(idx[1]), 64'(n));
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iv[0] = 1'b0; iv[1] = 1'b0;
    av[0] = '0; av[1] = '0; bv[0] = '0; bv[1] = '0;
    idx[0] = 0; idx[1] = 0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_out_valid%0d", k), 64'(k == 0 ? ch[0].ov  : ch[1].ov),  64'(0));
      chk($sformatf("rst_result%0d", k),    64'(k == 0 ? ch[0].res : ch[1].res), 64'(0));
      chk($sformatf("rst_overflow%0d", k),  64'(k == 0 ? ch[0].ovf : ch[1].ovf), 64'(0));
      chk($sformatf("rst_in_ready%0d", k),  64'(k == 0 ? ch[0].ir  : ch[1].ir),  64'(1));
    end
    @(posedge clk); #1;

    // Directed vectors; instance 0 truncates and saturates, instance 1 rounds and wraps.
    pa[0] = 32'h0001_8000; pb[0] = 32'h0002_0000;
    pa[1] = 32'hFFFE_8000; pb[1] = 32'h0002_0000;
    pa[2] = 32'h7FFF_0000; pb[2] = 32'h0002_0000;
    pa[3] = 32'h8000_0000; pb[3] = 32'h8000_0000;
    pa[4] = 32'h0000_0001; pb[4] = 32'h0000_8000;
    pa[5] = 32'hFFFF_FFFF; pb[5] = 32'h0000_8000;
    tab_r[0][0] = 32'h0003_0000; tab_o[0][0] = 1'b0;
    tab_r[0][1] = 32'hFFFD_0000; tab_o[0][1] = 1'b0;
    tab_r[0][2] = 32'h7FFF_FFFF; tab_o[0][2] = 1'b1;
    tab_r[0][3] = 32'h7FFF_FFFF; tab_o[0][3] = 1'b1;
    tab_r[0][4] = 32'h0000_0000; tab_o[0][4] = 1'b0;
    tab_r[0][5] = 32'hFFFF_FFFF; tab_o[0][5] = 1'b0;
    tab_r[1][0] = 32'h0003_0000; tab_o[1][0] = 1'b0;
    tab_r[1][1] = 32'hFFFD_0000; tab_o[1][1] = 1'b0;
    tab_r[1][2] = 32'hFFFE_0000; tab_o[1][2] = 1'b1;
    tab_r[1][3] = 32'h0000_0000; tab_o[1][3] = 1'b1;
    tab_r[1][4] = 32'h0000_0001; tab_o[1][4] = 1'b0;
    tab_r[1][5] = 32'h0000_0000; tab_o[1][5] = 1'b0;
    use_tab = 1'b1;
    chk_lat = 1'b1;
    run_phase(6, 0, 0, 1'b0);
    use_tab = 1'b0;

    // Streaming with a 5-cycle output stall mid-stream.
    for (int i = 0; i < 20; i++) begin
      pa[i] = rand_op();
      pb[i] = rand_op();
    end
    chk_lat = 1'b0;
    run_phase(20, 8, 5, 1'b0);

    // Random backpressure.
    for (int i = 0; i < 40; i++) begin
      pa[i] = rand_op();
      pb[i] = rand_op();
    end
    run_phase(40, 0, 0, 1'b1);

    // Reset with three products in flight and the output held off.
    for (int i = 0; i < 4; i++) begin
      pa[i] = rand_op();
      pb[i] = rand_op();
    end
    ordy = 1'b0;
    stalling = 1'b1;
    idx[0] = 0;
    idx[1] = 0;
    for (int c = 0; c < 10; c++) begin
      if (idx[0] >= 3 && idx[1] >= 3) break;
      for (int k = 0; k < 2; k++) begin
        iv[k] = (idx[k] < 3);
        if (idx[k] < 3) begin
          av[k] = pa[idx[k]];
          bv[k] = pb[idx[k]];
        end
      end
      @(posedge clk); #1;
      if (ch[0].acc) idx[0]++;
      if (ch[1].acc) idx[1]++;
    end
    chk("rst_pre_accepted0", 64'(idx[0]), 64'(3));
    chk("rst_pre_accepted1", 64'(idx[1]), 64'(3));
    iv[0] = 1'b0;
    iv[1] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ordy = 1'b1;
    stalling = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b1;
      av[k] = pa[3];
      bv[k] = pb[3];
    end
    @(negedge clk);
    chk("post_rst_out_valid0", 64'(ch[0].ov),  64'(0));
    chk("post_rst_result0",    64'(ch[0].res), 64'(0));
    chk("post_rst_overflow0",  64'(ch[0].ovf), 64'(0));
    chk("post_rst_in_ready0",  64'(ch[0].ir),  64'(1));
    chk("post_rst_out_valid1", 64'(ch[1].ov),  64'(0));
    chk("post_rst_in_ready1",  64'(ch[1].ir),  64'(1));
    @(posedge clk); #1;
    chk("accept_after_rst0", 64'(ch[0].acc), 64'(1));
    chk("accept_after_rst1", 64'(ch[1].acc), 64'(1));
    iv[0] = 1'b0;
    iv[1] = 1'b0;
    drain();
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
